// File: rtl/iob_clint_arbiter_pkg.sv
// Shared FSM encoding and grant-index width helper for the CLINT arbiter.
package iob_clint_arbiter_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  function automatic int gnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_arb_sel.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module iob_rr_arb_sel
  import iob_clint_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = gnt_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    off;
  logic [IW:0]    sum;

  // rot[i] is the request of master (ptr+i) mod N
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  assign any = |req;

  always_comb begin
    off = '0;
    for (int i = N-1; i >= 0; i--)
      if (rot[i]) off = (IW+1)'(i);
    sum = {1'b0, ptr} + off;
    if (sum >= NV) sum = sum - NV;
    gnt_idx = sum[IW-1:0];
  end

endmodule

// File: rtl/iob_clint_arbiter.sv
// Round-robin arbiter sharing one IOb-native CLINT slave among N_MASTERS requesters,
// with registered request payload and a per-access stall timeout.
module iob_clint_arbiter
  import iob_clint_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_address,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic [gnt_w(N_MASTERS)-1:0]     grant_id,
  output logic                            timeout_err
);

  localparam int IW = gnt_w(N_MASTERS);
  localparam int SW = DATA_W/8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT-1) : '0;
  localparam logic [IW-1:0] LAST_ID = IW'(N_MASTERS-1);

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, gid_q, gid_d, sel_idx, ptr_inc;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [SW-1:0]      wstrb_q, wstrb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sel_any, done, abort;

  iob_rr_arb_sel #(.N(N_MASTERS), .IW(IW)) u_sel (
    .req     (m_valid),
    .ptr     (ptr_q),
    .gnt_idx (sel_idx),
    .any     (sel_any)
  );

  assign done    = (state_q == ST_REQ) && s_ready;
  assign abort   = (state_q == ST_REQ) && !s_ready && (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign ptr_inc = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (sel_any) state_d = ST_REQ;
    end else if (done || abort) begin
      state_d = ST_IDLE;
    end
  end

  // Response demux: ready and data go only to the granted master
  always_comb begin
    s_valid     = (state_q == ST_REQ);
    m_ready     = '0;
    m_rdata     = '0;
    timeout_err = 1'b0;
    if (done) begin
      m_ready[gid_q] = 1'b1;
      m_rdata        = s_rdata;
    end else if (abort) begin
      m_ready[gid_q] = 1'b1;
      timeout_err    = 1'b1;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (sel_any) begin
        gid_d   = sel_idx;
        addr_d  = m_address[sel_idx*ADDR_W +: ADDR_W];
        wdata_d = m_wdata[sel_idx*DATA_W +: DATA_W];
        wstrb_d = m_wstrb[sel_idx*SW +: SW];
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (done || abort) ptr_d = ptr_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      gid_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id  = gid_q;
  assign s_address = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;

endmodule
